// File: rtl/axi_sram_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_stream_reader_pkg
// Description : Shared definitions for the AXI-Lite SRAM stream reader:
//               FSM state encoding, AXI response codes and the helper that
//               sizes the output FIFO occupancy counter.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_sram_stream_reader_pkg;

   // Read-engine states; the "wait for FIFO slot" condition lives inside
   // ST_ADDR with arvalid low, so no separate encoding is needed.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   // Occupancy counter must represent 0..DEPTH inclusive.
   function automatic int fifo_count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_sram_stream_reader_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO with occupancy
//               count. Head word is visible on pop_data whenever empty=0.
//               Push into a full FIFO and pop from an empty FIFO are ignored.
// Ports       : clk, rst_n (async active-low)
//               push, push_data      - write side
//               pop, pop_data        - read side (FWFT)
//               count, empty         - status
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
   import axi_sram_stream_reader_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = fifo_count_width(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   output logic [WIDTH-1:0]     pop_data,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 empty
);

   localparam int c_PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]     r_mem [DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [CNT_WIDTH-1:0] r_count;
   logic                 w_do_push;
   logic                 w_do_pop;

   assign w_do_push = push && (r_count != CNT_WIDTH'(DEPTH));
   assign w_do_pop  = pop && (r_count != '0);

   // Storage is reset so the head word reads as zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign pop_data = r_mem[r_rd_ptr];
   assign count    = r_count;
   assign empty    = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/axi_sram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_stream_reader
// Description : AXI-Lite read master. On start it issues len single-beat
//               reads from base_addr upward (address wraps silently) with at
//               most one read outstanding, and streams the returned words out
//               through an FWFT FIFO. A read is only issued once a FIFO slot
//               is reserved for it, so no returned word is ever dropped.
// Ports       : axi_aclk, axi_aresetn (async active-low)
//               start, base_addr, len     - transfer request
//               busy, done                - transfer status
//               m_axi_ar*, m_axi_r*       - AXI-Lite read channels
//               out_data/valid/ready      - output stream
//               rresp_err                 - sticky error (optional)
// Config      : define AXI_SRAM_STREAM_READER_RRESP_CHECK_EN to add the
//               rresp_err port; otherwise rresp is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_stream_reader
   import axi_sram_stream_reader_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 20,
   parameter int AXI_DATA_WIDTH = 16,
   parameter int LEN_WIDTH      = 20,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      axi_aclk,
   input  logic                      axi_aresetn,
   input  logic                      start,
   input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]      len,
   output logic                      busy,
   output logic                      done,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   output logic [AXI_DATA_WIDTH-1:0] out_data,
   output logic                      out_valid,
   input  logic                      out_ready
`ifdef AXI_SRAM_STREAM_READER_RRESP_CHECK_EN
   ,
   output logic                      rresp_err
`endif
);

   localparam int c_CNT_W = fifo_count_width(FIFO_DEPTH);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [AXI_ADDR_WIDTH-1:0] r_addr;
   logic [AXI_ADDR_WIDTH-1:0] w_addr_nxt;
   logic [LEN_WIDTH-1:0]      r_remaining;
   logic [LEN_WIDTH-1:0]      w_remaining_nxt;
   logic                      r_arvalid;
   logic                      w_arvalid_nxt;
   logic                      r_busy;
   logic                      w_busy_nxt;
   logic                      r_done;
   logic                      w_done_nxt;

   logic                      w_ar_hs;
   logic                      w_rready;
   logic                      w_r_accept;
   logic                      w_pop;
   logic                      w_fifo_empty;
   logic [c_CNT_W-1:0]        w_fifo_count;
   logic [c_CNT_W:0]          w_count_nxt;
   logic                      w_slot_free;
   logic                      w_last_beat;

   assign w_ar_hs  = r_arvalid & m_axi_arready;
   assign w_rready = (r_state != ST_IDLE);

   // Only take an R beat when a read is actually in flight: either already
   // issued (DATA) or handshaking right now (ADDR with arready). This keeps
   // the slot reservation intact even against a misbehaving slave.
   assign w_r_accept = m_axi_rvalid & w_rready &
                       ((r_state == ST_DATA) | ((r_state == ST_ADDR) & w_ar_hs));

   assign w_pop = ~w_fifo_empty & out_ready;

   // Occupancy after this cycle's push and pop; a new read may be issued
   // only if that leaves room for its beat.
   assign w_count_nxt = {1'b0, w_fifo_count}
                      + {{c_CNT_W{1'b0}}, w_r_accept}
                      - {{c_CNT_W{1'b0}}, w_pop};
   assign w_slot_free = (w_count_nxt < (c_CNT_W + 1)'(FIFO_DEPTH));
   assign w_last_beat = (r_remaining == LEN_WIDTH'(1));

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
         r_arvalid   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_addr      <= w_addr_nxt;
         r_remaining <= w_remaining_nxt;
         r_arvalid   <= w_arvalid_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_addr_nxt      = r_addr;
      w_remaining_nxt = r_remaining;
      w_arvalid_nxt   = r_arvalid;
      w_busy_nxt      = r_busy;
      w_done_nxt      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_addr_nxt      = base_addr;
               w_remaining_nxt = len;
               if (len == '0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_state_nxt   = ST_ADDR;
                  w_busy_nxt    = 1'b1;
                  w_arvalid_nxt = w_slot_free;
               end
            end
         end
         ST_ADDR: begin
            if (r_arvalid) begin
               if (w_ar_hs && !m_axi_rvalid) begin
                  w_state_nxt   = ST_DATA;
                  w_arvalid_nxt = 1'b0;
               end
            end else begin
               // Waiting for the consumer to free a slot.
               w_arvalid_nxt = w_slot_free;
            end
         end
         ST_DATA: begin
            w_arvalid_nxt = 1'b0;
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_arvalid_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
         end
      endcase

      // Beat completion is common to ADDR (same-cycle R) and DATA.
      if (w_r_accept) begin
         w_addr_nxt      = r_addr + 1'b1;
         w_remaining_nxt = r_remaining - 1'b1;
         if (w_last_beat) begin
            w_state_nxt   = ST_IDLE;
            w_arvalid_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b1;
         end else begin
            w_state_nxt   = ST_ADDR;
            w_arvalid_nxt = w_slot_free;
         end
      end
   end

   sync_fifo #(
      .WIDTH     (AXI_DATA_WIDTH),
      .DEPTH     (FIFO_DEPTH),
      .CNT_WIDTH (c_CNT_W)
   ) u_out_fifo (
      .clk       (axi_aclk),
      .rst_n     (axi_aresetn),
      .push      (w_r_accept),
      .push_data (m_axi_rdata),
      .pop       (w_pop),
      .pop_data  (out_data),
      .count     (w_fifo_count),
      .empty     (w_fifo_empty)
   );

`ifdef AXI_SRAM_STREAM_READER_RRESP_CHECK_EN
   logic r_rresp_err;
   logic w_rresp_err_nxt;

   always_comb begin
      w_rresp_err_nxt = r_rresp_err;
      if ((r_state == ST_IDLE) && start) begin
         w_rresp_err_nxt = 1'b0;
      end else if (w_r_accept && (m_axi_rresp != RESP_OKAY)) begin
         w_rresp_err_nxt = 1'b1;
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_rresp_err <= 1'b0;
      end else begin
         r_rresp_err <= w_rresp_err_nxt;
      end
   end

   assign rresp_err = r_rresp_err;
`else
   logic w_unused_rresp;
   assign w_unused_rresp = ^m_axi_rresp;
`endif

   assign busy          = r_busy;
   assign done          = r_done;
   assign m_axi_araddr  = r_addr;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_rready  = w_rready;
   assign out_valid     = ~w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_sram_stream_reader
// Description : Self-checking bench. A behavioural slave answers reads with
//               rdata = address[15:0]; a transaction-level model predicts the
//               output word stream, FIFO occupancy, done/busy timing and the
//               AR address sequence, and is compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_sram_stream_reader;

   localparam int FIFO_DEPTH = 4;

   logic        clk = 1'b0;
   logic        axi_aresetn;
   logic        start;
   logic [19:0] base_addr;
   logic [19:0] len;
   logic        busy, done;
   logic [19:0] m_axi_araddr;
   logic        m_axi_arvalid, m_axi_arready;
   logic [15:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rvalid, m_axi_rready;
   logic [15:0] out_data;
   logic        out_valid, out_ready;
`ifdef AXI_SRAM_STREAM_READER_RRESP_CHECK_EN
   logic        rresp_err;
`endif

   axi_sram_stream_reader #(
      .AXI_ADDR_WIDTH (20),
      .AXI_DATA_WIDTH (16),
      .LEN_WIDTH      (20),
      .FIFO_DEPTH     (FIFO_DEPTH)
   ) dut (
      .axi_aclk      (clk),
      .axi_aresetn   (axi_aresetn),
      .start         (start),
      .base_addr     (base_addr),
      .len           (len),
      .busy          (busy),
      .done          (done),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready)
`ifdef AXI_SRAM_STREAM_READER_RRESP_CHECK_EN
      ,
      .rresp_err     (rresp_err)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- slave ----------------
   int          ar_delay = 1;
   int          r_delay  = 0;
   int          s_ar_cnt = 0;
   int          s_r_cnt  = 0;
   logic        s_pend   = 1'b0;
   logic [19:0] s_addr;
   logic        err_en   = 1'b0;
   logic [19:0] err_addr = '0;

   task automatic drive_r(input logic [19:0] a);
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = a[15:0];
      m_axi_rresp  = (err_en && a == err_addr) ? 2'b10 : 2'b00;
   endtask

   task automatic slave_drive();
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_rresp   = 2'b00;
      if (!axi_aresetn) begin
         s_pend   = 1'b0;
         s_ar_cnt = 0;
      end else if (s_pend) begin
         s_r_cnt--;
         if (s_r_cnt == 0) begin
            drive_r(s_addr);
            s_pend = 1'b0;
         end
      end else if (m_axi_arvalid) begin
         if (s_ar_cnt >= ar_delay) begin
            m_axi_arready = 1'b1;
            s_ar_cnt      = 0;
            s_addr        = m_axi_araddr;
            if (r_delay == 0) drive_r(s_addr);
            else begin
               s_pend  = 1'b1;
               s_r_cnt = r_delay;
            end
         end else begin
            s_ar_cnt++;
         end
      end
   endtask

   // ---------------- model ----------------
   logic [15:0] q[$];
   int          m_occ = 0, m_outst = 0, m_beats_left = 0, m_ar_left = 0;
   logic [19:0] m_exp_addr = '0;
   logic        m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;

   logic [15:0] out_log[$];
   logic [19:0] ar_log[$];
   int          ar_cyc[$];
   int          cyc = 0, done_cnt = 0, arv_cnt = 0, start_cyc = -1, first_arv_cyc = -1;

   task automatic sample_cycle();
      logic        nb_done, nb_busy, nb_err;
      logic [19:0] a;
      cyc++;
      if (!axi_aresetn) begin
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_arvalid", m_axi_arvalid, 0);
         chk("rst_araddr", m_axi_araddr, 0);
         chk("rst_rready", m_axi_rready, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_data", out_data, 0);
`ifdef AXI_SRAM_STREAM_READER_RRESP_CHECK_EN
         chk("rst_rresp_err", rresp_err, 0);
`endif
         q.delete();
         m_occ = 0; m_outst = 0; m_beats_left = 0; m_ar_left = 0;
         m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
         s_pend = 1'b0; s_ar_cnt = 0;
         return;
      end

      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("out_valid", out_valid, (m_occ > 0));
      if (m_occ > 0 && q.size() > 0) chk("out_data", out_data, q[0]);
      if (!m_busy) chk("arvalid_idle", m_axi_arvalid, 0);
      if (m_axi_arvalid) begin
         chk("araddr", m_axi_araddr, m_exp_addr);
         chk("ar_slot_reserved", (m_occ < FIFO_DEPTH), 1);
         chk("ar_outstanding", m_outst, 0);
      end
      if (m_outst > 0 || m_axi_arvalid) chk("rready", m_axi_rready, 1);
`ifdef AXI_SRAM_STREAM_READER_RRESP_CHECK_EN
      chk("rresp_err", rresp_err, m_err);
`endif

      nb_done = 1'b0;
      nb_busy = m_busy;
      nb_err  = m_err;
      if (out_valid && out_ready) begin
         out_log.push_back(out_data);
         if (q.size() > 0) void'(q.pop_front());
         if (m_occ > 0) m_occ--;
      end
      if (m_axi_arvalid) begin
         arv_cnt++;
         if (first_arv_cyc < 0) first_arv_cyc = cyc;
      end
      if (m_axi_arvalid && m_axi_arready) begin
         chk("ar_extra", (m_ar_left > 0), 1);
         ar_log.push_back(m_axi_araddr);
         ar_cyc.push_back(cyc);
         m_exp_addr++;
         m_ar_left--;
         m_outst++;
      end
      if (m_axi_rvalid && m_axi_rready) begin
         m_occ++;
         m_outst--;
         m_beats_left--;
         chk("fifo_overflow", (m_occ <= FIFO_DEPTH), 1);
         if (m_axi_rresp != 2'b00) nb_err = 1'b1;
         if (m_beats_left == 0) begin
            nb_done = 1'b1;
            nb_busy = 1'b0;
         end
      end
      if (start && !m_busy) begin
         start_cyc = cyc;
         nb_err    = 1'b0;
         if (len == 0) nb_done = 1'b1;
         else begin
            nb_busy      = 1'b1;
            m_exp_addr   = base_addr;
            m_ar_left    = int'(len);
            m_beats_left = int'(len);
            for (int i = 0; i < int'(len); i++) begin
               a = base_addr + 20'(i);
               q.push_back(a[15:0]);
            end
         end
      end
      if (done) done_cnt++;
      m_done = nb_done;
      m_busy = nb_busy;
      m_err  = nb_err;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         slave_drive();
         #1;
         sample_cycle();
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_xfer(input logic [19:0] b, input logic [19:0] l);
      @(negedge clk);
      start = 1'b1; base_addr = b; len = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string nm);
      int  c0;
      logic seen;
      c0   = done_cnt;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk); #2;
         if (done_cnt != c0) seen = 1'b1;
      end
      chk(nm, seen, 1);
   endtask

   task automatic wait_drain(input int budget, input string nm);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk); #2;
         if (q.size() == 0 && m_occ == 0) ok = 1'b1;
      end
      chk(nm, ok, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc0;
      axi_aresetn = 1'b0;
      start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
      repeat (3) @(negedge clk);
      axi_aresetn = 1'b1;
      repeat (2) @(negedge clk);

      // 1: basic 4-beat transfer, ideal companion slave
      out_log.delete(); ar_cyc.delete(); first_arv_cyc = -1; dc0 = done_cnt;
      start_xfer(20'h00010, 20'd4);
      wait_done(40, "t1_done_timeout");
      wait_drain(20, "t1_drain");
      repeat (3) @(negedge clk); #2;
      chk("t1_done_once", done_cnt - dc0, 1);
      chk("t1_first_arvalid_lat", first_arv_cyc - start_cyc, 1);
      chk("t1_beat_period", ar_cyc[1] - ar_cyc[0], 2);
      chk("t1_words", out_log.size(), 4);
      chk("t1_w0", out_log[0], 16'h0010);
      chk("t1_w1", out_log[1], 16'h0011);
      chk("t1_w2", out_log[2], 16'h0012);
      chk("t1_w3", out_log[3], 16'h0013);

      // 2: len=0 -> done only, no AR
      arv_cnt = 0; dc0 = done_cnt;
      start_xfer(20'h00050, 20'd0);
      wait_done(5, "t2_done_timeout");
      repeat (4) @(negedge clk); #2;
      chk("t2_no_arvalid", arv_cnt, 0);
      chk("t2_done_once", done_cnt - dc0, 1);

      // 3: address wrap
      ar_log.delete();
      start_xfer(20'hFFFFE, 20'd4);
      wait_done(40, "t3_done_timeout");
      wait_drain(20, "t3_drain");
      chk("t3_a0", ar_log[0], 20'hFFFFE);
      chk("t3_a1", ar_log[1], 20'hFFFFF);
      chk("t3_a2", ar_log[2], 20'h00000);
      chk("t3_a3", ar_log[3], 20'h00001);

      // 4: back-pressure: FIFO fills, AR stops, then all 10 words drain
      ar_log.delete(); out_log.delete(); out_ready = 1'b0;
      start_xfer(20'h00100, 20'd10);
      repeat (30) @(negedge clk); #2;
      chk("t4_ar_count_stalled", ar_log.size(), 4);
      chk("t4_arvalid_low", m_axi_arvalid, 0);
      chk("t4_out_valid", out_valid, 1);
      @(negedge clk); out_ready = 1'b1;
      wait_done(60, "t4_done_timeout");
      wait_drain(20, "t4_drain");
      chk("t4_words", out_log.size(), 10);
      chk("t4_w9", out_log[9], 16'h0109);

      // 5: slow slave; a start while busy must be ignored
      ar_delay = 2; r_delay = 3; out_log.delete();
      start_xfer(20'h00200, 20'd3);
      repeat (2) @(negedge clk);
      start_xfer(20'h07777, 20'd5);
      wait_done(60, "t5_done_timeout");
      wait_drain(20, "t5_drain");
      repeat (5) @(negedge clk); #2;
      chk("t5_words", out_log.size(), 3);
      chk("t5_w2", out_log[2], 16'h0202);
      chk("t5_busy_low", busy, 0);
      ar_delay = 1; r_delay = 0;

      // 6: reset in the middle of an 8-beat transfer, then a fresh transfer
      ar_log.delete(); out_log.delete();
      start_xfer(20'h00300, 20'd8);
      for (int i = 0; i < 40 && ar_log.size() < 2; i++) @(negedge clk);
      chk("t6_reached_beat2", (ar_log.size() >= 2), 1);
      dc0 = done_cnt;
      axi_aresetn = 1'b0;
      repeat (2) @(negedge clk);
      axi_aresetn = 1'b1;
      repeat (3) @(negedge clk); #2;
      chk("t6_no_done", done_cnt - dc0, 0);
      chk("t6_fifo_empty", out_valid, 0);
      chk("t6_idle", busy, 0);
      out_log.delete();
      start_xfer(20'h00400, 20'd2);
      wait_done(30, "t6_done_timeout");
      wait_drain(20, "t6_drain");
      chk("t6_words", out_log.size(), 2);
      chk("t6_w0", out_log[0], 16'h0400);
      chk("t6_w1", out_log[1], 16'h0401);

`ifdef AXI_SRAM_STREAM_READER_RRESP_CHECK_EN
      // 7: error response is sticky until the next start
      err_en = 1'b1; err_addr = 20'h00501; out_log.delete();
      start_xfer(20'h00500, 20'd3);
      wait_done(30, "t7_done_timeout");
      wait_drain(20, "t7_drain");
      repeat (3) @(negedge clk); #2;
      chk("t7_err_sticky", rresp_err, 1);
      chk("t7_words", out_log.size(), 3);
      chk("t7_w1", out_log[1], 16'h0501);
      err_en = 1'b0;
      start_xfer(20'h00600, 20'd1);
      #2;
      chk("t7_err_cleared", rresp_err, 0);
      wait_done(20, "t7b_done_timeout");
      wait_drain(20, "t7b_drain");
`endif

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
